// File: rtl/bram_wb_arbiter.sv
// Four-master Wishbone arbiter for the shared blockram port: round-robin per
// complete bus cycle, combinational slave mux and ack return, stall watchdog.
module bram_wb_arbiter #(
   parameter int TIMEOUT = 255
) (
   input  logic         wb_clk_i,
   input  logic         reset,
   input  logic [3:0]   m_cyc_i,
   input  logic [3:0]   m_stb_i,
   input  logic [3:0]   m_we_i,
   input  logic [15:0]  m_sel_i,
   input  logic [127:0] m_adr_i,
   input  logic [127:0] m_dat_i,
   output logic [3:0]   m_ack_o,
   output logic [3:0]   m_err_o,
   output logic [31:0]  m_dat_o,
   output logic         s_cyc_o,
   output logic         s_stb_o,
   output logic         s_we_o,
   output logic [3:0]   s_sel_o,
   output logic [31:0]  s_adr_o,
   output logic [31:0]  s_dat_o,
   input  logic [31:0]  s_dat_i,
   input  logic         s_ack_i,
   output logic [1:0]   grant_o,
   output logic         busy_o,
   output logic [7:0]   err_count_o
);

   typedef enum logic [1:0] {IDLE, GRANT, ABORT} state_e;

   localparam int            CW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam bit            WD_EN    = (TIMEOUT > 0);

   state_e        state_q, state_d;
   logic [1:0]    grant_q, grant_d;
   logic [1:0]    last_q, last_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]    err_q, err_d;
   logic [7:0]    errcnt_q, errcnt_d;

   logic [1:0]    pick;
   logic          pick_vld;
   logic [1:0]    idx;

   logic          g_cyc, g_stb, g_we;
   logic [3:0]    g_sel;
   logic [31:0]   g_adr, g_dat;

   // Rotating search from last+1; iterating downward lets the nearest requester win.
   always_comb begin
      pick     = '0;
      pick_vld = 1'b0;
      idx      = '0;
      for (int k = 4; k >= 1; k--) begin
         idx = last_q + 2'(k);
         if (m_cyc_i[idx]) begin
            pick     = idx;
            pick_vld = 1'b1;
         end
      end
   end

   assign g_cyc = m_cyc_i[grant_q];
   assign g_stb = m_stb_i[grant_q];
   assign g_we  = m_we_i[grant_q];
   assign g_sel = m_sel_i[{grant_q, 2'b00} +: 4];
   assign g_adr = m_adr_i[{grant_q, 5'b00000} +: 32];
   assign g_dat = m_dat_i[{grant_q, 5'b00000} +: 32];

   always_comb begin
      s_cyc_o = 1'b0;
      s_stb_o = 1'b0;
      s_we_o  = 1'b0;
      s_sel_o = '0;
      s_adr_o = '0;
      s_dat_o = '0;
      m_ack_o = '0;
      if (state_q == GRANT) begin
         s_cyc_o          = g_cyc;
         s_stb_o          = g_cyc & g_stb;
         s_we_o           = g_we;
         s_sel_o          = g_sel;
         s_adr_o          = g_adr;
         s_dat_o          = g_dat;
         m_ack_o[grant_q] = s_ack_i;
      end
   end

   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      last_d   = last_q;
      cnt_d    = cnt_q;
      err_d    = '0;
      errcnt_d = errcnt_q;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (pick_vld) begin
               grant_d = pick;
               state_d = GRANT;
            end
         end
         GRANT: begin
            if (!g_cyc) begin
               last_d  = grant_q;
               cnt_d   = '0;
               state_d = IDLE;
            end else if (WD_EN && g_stb && !s_ack_i) begin
               // An ack arriving in the last allowed cycle never reaches this branch.
               if (cnt_q == CNT_LAST) begin
                  err_d[grant_q] = 1'b1;
                  if (errcnt_q != 8'hFF) errcnt_d = errcnt_q + 8'd1;
                  cnt_d   = '0;
                  state_d = ABORT;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end else begin
               cnt_d = '0;
            end
         end
         ABORT: begin
            if (!g_cyc) begin
               last_d  = grant_q;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // last resets to 3 so that master 0 is searched first.
   always_ff @(posedge wb_clk_i or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         grant_q  <= 2'd0;
         last_q   <= 2'd3;
         cnt_q    <= '0;
         err_q    <= '0;
         errcnt_q <= '0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         last_q   <= last_d;
         cnt_q    <= cnt_d;
         err_q    <= err_d;
         errcnt_q <= errcnt_d;
      end
   end

   assign m_err_o     = err_q;
   assign m_dat_o     = s_dat_i;
   assign grant_o     = grant_q;
   assign busy_o      = (state_q != IDLE);
   assign err_count_o = errcnt_q;

endmodule

// File: tb/tb_bram_wb_arbiter.sv
// Directed bench for bram_wb_arbiter: bench-driven masters and slave, a
// cycle-level ownership model checked every cycle, plus literal expectations.
module tb_bram_wb_arbiter;
   localparam int TO = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [3:0]   m_cyc_i = '0, m_stb_i = '0, m_we_i = '0;
   logic [15:0]  m_sel_i = '0;
   logic [127:0] m_adr_i = '0, m_dat_i = '0;
   logic [3:0]   m_ack_o, m_err_o;
   logic [31:0]  m_dat_o;
   logic         s_cyc_o, s_stb_o, s_we_o;
   logic [3:0]   s_sel_o;
   logic [31:0]  s_adr_o, s_dat_o;
   logic [31:0]  s_dat_i = '0;
   logic         s_ack_i = 1'b0;
   logic [1:0]   grant_o;
   logic         busy_o;
   logic [7:0]   err_count_o;

   always #5 clk = ~clk;

   bram_wb_arbiter #(.TIMEOUT(TO)) dut (
      .wb_clk_i(clk), .reset(rst),
      .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i), .m_sel_i(m_sel_i),
      .m_adr_i(m_adr_i), .m_dat_i(m_dat_i),
      .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_dat_o(m_dat_o),
      .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
      .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
      .grant_o(grant_o), .busy_o(busy_o), .err_count_o(err_count_o)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Ownership model: who owns the bus, whether the owner was cut off, and how
   // long the owner's current strobe has gone unanswered.
   int       mown = -1;
   bit       mabt = 0;
   int       mlast = 3, mgnt = 0, mrun = 0, mecnt = 0;
   logic [3:0] merr = '0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mown = -1; mabt = 0; mlast = 3; mgnt = 0; mrun = 0; mecnt = 0; merr = '0;
      end else begin
         merr = '0;
         if (mown < 0) begin
            for (int k = 1; k <= 4; k++)
               if (mown < 0 && m_cyc_i[(mlast + k) % 4]) begin
                  mown = (mlast + k) % 4;
                  mgnt = mown;
               end
         end else if (!m_cyc_i[mown]) begin
            mlast = mown; mown = -1; mabt = 0; mrun = 0;
         end else if (!mabt) begin
            if (m_stb_i[mown] && !s_ack_i) begin
               mrun++;
               if (mrun == TO) begin
                  merr[mown] = 1'b1;
                  if (mecnt < 255) mecnt++;
                  mabt = 1; mrun = 0;
               end
            end else begin
               mrun = 0;
            end
         end
      end
   end

   bit         e_act;
   int         g;
   logic [3:0] e_ack;

   always @(negedge clk) begin
      if (!rst) begin
         g     = mgnt;
         e_act = (mown >= 0) && !mabt;
         e_ack = '0;
         if (e_act) e_ack[g] = s_ack_i;
         chk("grant", grant_o, mgnt);
         chk("busy", busy_o, (mown >= 0));
         chk("err_count", err_count_o, mecnt);
         chk("m_err", m_err_o, merr);
         chk("m_ack", m_ack_o, e_ack);
         chk("s_cyc", s_cyc_o, e_act && m_cyc_i[g]);
         chk("s_stb", s_stb_o, e_act && m_cyc_i[g] && m_stb_i[g]);
         chk("s_we", s_we_o, e_act && m_we_i[g]);
         chk("s_sel", s_sel_o, e_act ? m_sel_i[4*g +: 4] : 4'h0);
         chk("s_adr", s_adr_o, e_act ? m_adr_i[32*g +: 32] : 32'h0);
         chk("s_dat", s_dat_o, e_act ? m_dat_i[32*g +: 32] : 32'h0);
         chk("m_dat", m_dat_o, s_dat_i);
      end
   end

   // Bench masters finish after blen acks (blen 0 = held by the test); the
   // slave acks after ack_dly unanswered strobe cycles when ack_on is set.
   int         blen[4] = '{0, 0, 0, 0};
   int         acks[4] = '{0, 0, 0, 0};
   logic [3:0] ack_seen = '0;
   int         scnt = 0;
   bit         ack_on = 1;
   int         ack_dly = 0;

   always @(negedge clk) begin
      ack_seen = m_ack_o;
      scnt = (s_stb_o && !s_ack_i) ? scnt + 1 : 0;
   end

   task automatic step();
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++)
         if (blen[i] != 0 && m_cyc_i[i] && ack_seen[i]) begin
            acks[i]++;
            if (acks[i] >= blen[i]) begin
               m_cyc_i[i] = 1'b0;
               m_stb_i[i] = 1'b0;
            end else begin
               m_adr_i[32*i +: 32] = m_adr_i[32*i +: 32] + 32'd4;
               m_dat_i[32*i +: 32] = m_dat_i[32*i +: 32] + 32'd1;
            end
         end
      #1;
      s_dat_i = $urandom;
      s_ack_i = ack_on && s_stb_o && (scnt == ack_dly);
   endtask

   task automatic start(input int i, input int len, input logic [31:0] adr,
                        input logic [31:0] dat, input logic we);
      m_cyc_i[i] = 1'b1;
      m_stb_i[i] = 1'b1;
      m_we_i[i]  = we;
      m_sel_i[4*i +: 4]   = 4'hF;
      m_adr_i[32*i +: 32] = adr;
      m_dat_i[32*i +: 32] = dat;
      blen[i] = len;
      acks[i] = 0;
   endtask

   task automatic wait_idle(input string nm);
      int c;
      c = 0;
      do begin
         step();
         @(negedge clk);
         c++;
      end while (busy_o && c < 40);
      chk({nm, "_idle_budget"}, busy_o, 1'b0);
   endtask

   int order[$];
   int gaps[$];
   int idle_n, n0, n1, nack, errhi, n_ack1, cnt;
   bit pb, req0, found, errseen;
   logic [3:0] errval;
   int exp_order[5] = '{0, 1, 2, 3, 0};

   initial begin
      repeat (2) @(posedge clk);
      #3 rst = 1'b0;
      @(negedge clk);
      chk("rst_grant", grant_o, 2'd0);
      chk("rst_busy", busy_o, 1'b0);
      chk("rst_errcnt", err_count_o, 8'd0);
      chk("rst_merr", m_err_o, 4'd0);
      chk("rst_scyc", s_cyc_o, 1'b0);

      // single master 2
      step();
      start(2, 1, 32'h10, 32'hABCDEF01, 1'b1);
      @(negedge clk);
      chk("t1_not_yet", s_cyc_o, 1'b0);
      step();
      @(negedge clk);
      chk("t1_scyc", s_cyc_o, 1'b1);
      chk("t1_adr", s_adr_o, 32'h10);
      chk("t1_dat", s_dat_o, 32'hABCDEF01);
      chk("t1_ack", m_ack_o, 4'b0100);
      chk("t1_grant", grant_o, 2'd2);
      step();
      step();
      @(negedge clk);
      chk("t1_idle", busy_o, 1'b0);
      chk("t1_grant_kept", grant_o, 2'd2);

      // contention from reset
      #2 rst = 1'b1;
      for (int i = 0; i < 4; i++) start(i, 1, 32'h1000 * i, 32'h11 * i, 1'b1);
      #2 rst = 1'b0;
      pb = 0; idle_n = 0; req0 = 0;
      for (int c = 0; c < 60 && order.size() < 5; c++) begin
         step();
         if (req0) begin
            start(0, 1, 32'h0F00, 32'h55, 1'b0);
            req0 = 0;
         end
         @(negedge clk);
         if (busy_o && !pb) begin
            order.push_back(grant_o);
            gaps.push_back(idle_n);
            idle_n = 0;
            if (order.size() == 4) req0 = 1;
         end
         if (!busy_o) idle_n++;
         pb = busy_o;
      end
      chk("t2_grants_seen", order.size(), 5);
      if (order.size() == 5)
         for (int j = 0; j < 5; j++) begin
            chk("t2_order", order[j], exp_order[j]);
            if (j > 0) chk("t2_gap", gaps[j], 1);
         end
      wait_idle("t2");

      // burst hold: master 1 holds cyc over 8 transfers while master 0 waits
      start(1, 8, 32'h100, 32'h200, 1'b1);
      n_ack1 = 0; found = 0;
      for (int c = 0; c < 40 && !found; c++) begin
         step();
         if (c == 1) start(0, 1, 32'h200, 32'h300, 1'b1);
         @(negedge clk);
         if (m_ack_o[1]) n_ack1++;
         if (busy_o && grant_o == 2'd0 && s_cyc_o) found = 1;
      end
      chk("t3_m0_granted", found, 1'b1);
      chk("t3_acks_before_m0", n_ack1, 8);
      chk("t3_m1_done", acks[1], 8);
      wait_idle("t3");

      // timeout: slave silent toward master 3
      ack_on = 0;
      start(3, 0, 32'h300, 32'h400, 1'b1);
      n0 = -1; n1 = -1; errhi = 0; cnt = 0; errval = '0;
      for (int c = 0; c < 30; c++) begin
         step();
         @(negedge clk);
         cnt++;
         if (s_stb_o && n0 < 0) n0 = cnt;
         if (m_err_o != 4'd0) begin
            if (n1 < 0) n1 = cnt;
            errhi++;
            errval = m_err_o;
         end
         if (n1 >= 0 && cnt >= n1 + 2) break;
      end
      chk("t4_err_seen", (n1 >= 0), 1'b1);
      chk("t4_err_delay", n1 - n0, 4);
      chk("t4_err_val", errval, 4'b1000);
      chk("t4_err_width", errhi, 1);
      chk("t4_errcnt", err_count_o, 8'd1);
      chk("t4_abort_scyc", s_cyc_o, 1'b0);
      chk("t4_abort_busy", busy_o, 1'b1);
      step();
      m_cyc_i[3] = 1'b0;
      m_stb_i[3] = 1'b0;
      step();
      step();
      @(negedge clk);
      chk("t4_idle", busy_o, 1'b0);

      // ack in the last allowed cycle
      ack_on = 1;
      ack_dly = TO - 1;
      start(3, 1, 32'h340, 32'h440, 1'b1);
      n0 = -1; nack = -1; errseen = 0; cnt = 0;
      for (int c = 0; c < 20; c++) begin
         step();
         @(negedge clk);
         cnt++;
         if (s_stb_o && n0 < 0) n0 = cnt;
         if (m_ack_o == 4'b1000 && nack < 0) nack = cnt;
         if (m_err_o != 4'd0) errseen = 1;
         if (nack >= 0 && !busy_o) break;
      end
      chk("t5_ack_seen", (nack >= 0), 1'b1);
      chk("t5_ack_cycle", nack - n0, TO - 1);
      chk("t5_no_err", errseen, 1'b0);
      chk("t5_errcnt", err_count_o, 8'd1);
      chk("t5_idle", busy_o, 1'b0);

      // async reset while master 2 owns the bus with ack high
      ack_on = 0;
      ack_dly = 0;
      start(2, 0, 32'h500, 32'h600, 1'b1);
      step();
      step();
      s_ack_i = 1'b1;
      @(negedge clk);
      chk("t6_pre_ack", m_ack_o, 4'b0100);
      chk("t6_pre_scyc", s_cyc_o, 1'b1);
      #1 rst = 1'b1;
      #1;
      chk("t6_rst_scyc", s_cyc_o, 1'b0);
      chk("t6_rst_ack", m_ack_o, 4'b0000);
      chk("t6_rst_busy", busy_o, 1'b0);
      chk("t6_rst_errcnt", err_count_o, 8'd0);
      s_ack_i = 1'b0;
      ack_on = 1;
      for (int i = 0; i < 4; i++) start(i, 1, 32'h700 + i, 32'h800 + i, 1'b0);
      #1 rst = 1'b0;
      step();
      @(negedge clk);
      chk("t6_first_grant", grant_o, 2'd0);
      chk("t6_first_scyc", s_cyc_o, 1'b1);
      for (int c = 0; c < 60 && (m_cyc_i != 4'd0 || busy_o); c++) begin
         step();
         @(negedge clk);
      end
      chk("t6_drained", {busy_o, m_cyc_i}, 5'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
